// File: rtl/mvm_out_collector.sv
// mvm_out_collector: captures the K serial 2B-bit MVM results that follow mvm_done,
// requantizes each to B bits (optional ReLU, round-half-up arithmetic shift, saturation),
// and buffers them in a first-word-fall-through FIFO on a valid/ready stream.
// Ports:
//   clk, reset       clock (rising edge), asynchronous active-low reset
//   mvm_done         rising level starts one capture of K results
//   mvm_data [2B]    signed MVM result stream, y[i] valid at capture posedge i
//   relu_en          forces negative results to zero (sampled per result)
//   out_data [B]     signed requantized FIFO head (0 when empty)
//   out_last         head entry is the last result of its vector
//   out_valid        FIFO non-empty
//   out_ready        consumer accepts head when out_valid && out_ready
//   busy             capture FSM not idle
//   saturated        sticky: some result clipped
//   overrun          sticky: some result dropped because the FIFO was full
module mvm_out_collector #(
  parameter int unsigned K     = 16,
  parameter int unsigned B     = 8,
  parameter int unsigned SHIFT = 4,
  parameter int unsigned LAT   = 1,
  parameter int unsigned DEPTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           mvm_done,
  input  logic [2*B-1:0] mvm_data,
  input  logic           relu_en,
  output logic [B-1:0]   out_data,
  output logic           out_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy,
  output logic           saturated,
  output logic           overrun
);

  localparam int unsigned DW       = 2 * B;
  localparam int unsigned IW       = DW + 1;
  localparam int unsigned IDX_W    = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned DLY_W    = (LAT > 2) ? $clog2(LAT) : 1;
  localparam int unsigned DLY_LOAD = (LAT >= 2) ? (LAT - 2) : 0;
  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1);

  localparam logic signed [IW-1:0] RND_V = (IW'(1) << SHIFT) >> 1;
  localparam logic signed [IW-1:0] MAX_V = IW'((2 ** (B - 1)) - 1);
  localparam logic signed [IW-1:0] MIN_V = ~MAX_V;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CAPTURE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic               done_q;
  logic               capture_c;
  logic               cap_last_c;

  logic signed [IW-1:0] v_c, r_c;
  logic                 sat_c;
  logic [B-1:0]         q_c;

  logic [B-1:0]       mem_data [DEPTH];
  logic               mem_last [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_c, pop_c, do_push_c, drop_c;
  logic               valid_q, busy_q, sat_q, ovr_q;

  // Capture FSM state register and counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      dly_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dly_q   <= dly_d;
      done_q  <= mvm_done;
    end
  end

  // Next state; the posedge that leaves WAIT/IDLE into CAPTURE is LAT posedges
  // after the rising done, so the first CAPTURE-state posedge samples y[0].
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dly_d      = dly_q;
    capture_c  = 1'b0;
    cap_last_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mvm_done && !done_q) begin
          idx_d = '0;
          if (LAT == 0) begin
            // y[0] is already on the bus at this posedge
            capture_c  = 1'b1;
            cap_last_c = (K == 1);
            if (K > 1) begin
              idx_d   = IDX_W'(1);
              state_d = S_CAPTURE;
            end
          end else if (LAT == 1) begin
            state_d = S_CAPTURE;
          end else begin
            dly_d   = DLY_W'(DLY_LOAD);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dly_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          dly_d = dly_q - DLY_W'(1);
        end
      end
      S_CAPTURE: begin
        capture_c  = 1'b1;
        cap_last_c = (idx_q == IDX_W'(K - 1));
        if (cap_last_c) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Requantize: ReLU, round-half-up arithmetic shift, clip to B bits
  always_comb begin
    v_c   = (relu_en && mvm_data[DW-1]) ? '0 : {mvm_data[DW-1], mvm_data};
    r_c   = (v_c + RND_V) >>> SHIFT;
    sat_c = 1'b0;
    q_c   = r_c[B-1:0];
    if (r_c > MAX_V) begin
      sat_c = 1'b1;
      q_c   = {1'b0, {(B-1){1'b1}}};
    end else if (r_c < MIN_V) begin
      sat_c = 1'b1;
      q_c   = {1'b1, {(B-1){1'b0}}};
    end
  end

  // FIFO control; a push at full only succeeds if the head leaves in the same cycle
  always_comb begin
    full_c    = (count_q == CNT_W'(DEPTH));
    pop_c     = valid_q && out_ready;
    do_push_c = capture_c && (!full_c || pop_c);
    drop_c    = capture_c && full_c && !pop_c;
    count_d   = count_q + CNT_W'(do_push_c) - CNT_W'(pop_c);
  end

  // FIFO storage (no reset needed; reads are masked by valid)
  always_ff @(posedge clk) begin
    if (do_push_c) begin
      mem_data[wr_ptr_q] <= q_c;
      mem_last[wr_ptr_q] <= cap_last_c;
    end
  end

  // FIFO pointers, occupancy, registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      sat_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      if (do_push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      valid_q <= (count_d != '0);
      busy_q  <= (state_d != S_IDLE);
      if (capture_c && sat_c) sat_q <= 1'b1;
      if (drop_c)             ovr_q <= 1'b1;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = valid_q ? mem_data[rd_ptr_q] : '0;
  assign out_last  = valid_q ? mem_last[rd_ptr_q] : 1'b0;
  assign busy      = busy_q;
  assign saturated = sat_q;
  assign overrun   = ovr_q;

endmodule
